// File: rtl/spi_pkg.sv
//============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI master: FSM state
//               encoding, command codes and frame field widths.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

package spi_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    CMD   = 3'd2,
    SHIFT = 3'd3,
    GAP   = 3'd4,
    RECV  = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Command type codes carried in cmd_data[9:8]
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int PAYLOAD_BITS = 10;
  localparam int RD_BITS      = 8;

  // Larger of two integers, used to size the shared phase counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_shift_reg.sv
//============================================================================
// Module      : spi_shift_reg
// Description : Generic MSB-first shift register with parallel load. Shifts
//               toward the MSB, taking shift_in at the LSB; load has
//               priority over shift.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [WIDTH-1:0] q
);

  // Parallel load or single-bit shift toward the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], shift_in};
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
//============================================================================
// Module      : spi_master
// Description : SPI initiator clocked directly by clk. Accepts a 10-bit
//               command over valid/ready, frames it on SS_n/MOSI (select
//               cycle, type bit, 10 payload bits MSB first) and, for
//               read-data commands, captures an 8-bit reply from MISO after
//               RD_GAP idle cycles. SS_n stays high MIN_IDLE cycles after
//               each frame.
//               Optional build macro SPI_MASTER_RD_ORDER_CHECK_EN: reject
//               (err pulse, no frame) a read-data command that is not
//               preceded by a read-address command.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_master
  import spi_pkg::*;
#(
  parameter int RD_GAP   = 2,
  parameter int MIN_IDLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       err,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  // One counter serves every multi-cycle phase (SHIFT, GAP, RECV, DONE)
  localparam int CNT_MAX = max_int(max_int(PAYLOAD_BITS, RD_BITS), max_int(RD_GAP, MIN_IDLE));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    is_rd, is_rd_nxt;
  logic                    ss_n_nxt, mosi_nxt;
  logic                    tx_load, tx_shift, rx_shift, rd_done;
  logic                    reject;
  logic [PAYLOAD_BITS-1:0] tx_q;
  logic [RD_BITS-1:0]      rx_q;
  logic                    unused_bits;

  assign cmd_ready   = (state == IDLE);
  assign unused_bits = ^{tx_q[PAYLOAD_BITS-2:0], rx_q[RD_BITS-1]};

  spi_shift_reg #(.WIDTH(PAYLOAD_BITS)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .load_data (cmd_data),
    .shift_en  (tx_shift),
    .shift_in  (1'b0),
    .q         (tx_q)
  );

  spi_shift_reg #(.WIDTH(RD_BITS)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .load_data ({RD_BITS{1'b0}}),
    .shift_en  (rx_shift),
    .shift_in  (MISO),
    .q         (rx_q)
  );

`ifdef SPI_MASTER_RD_ORDER_CHECK_EN
  logic rd_addr_sent;
  logic err_q;

  assign reject = (cmd_data[9:8] == CMD_RD_DATA) && !rd_addr_sent;
  assign err    = err_q;

  // Remember whether a read address has been sent since the last read-data frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_sent <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= cmd_ready && cmd_valid && reject;
      if (cmd_ready && cmd_valid) begin
        if (cmd_data[9:8] == CMD_RD_ADDR) begin
          rd_addr_sent <= 1'b1;
        end else if (cmd_data[9:8] == CMD_RD_DATA) begin
          rd_addr_sent <= 1'b0;
        end
      end
    end
  end
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  // State, phase counter and latched command type
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      is_rd <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      is_rd <= is_rd_nxt;
    end
  end

  // Registered line outputs and read-reply capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      SS_n     <= ss_n_nxt;
      MOSI     <= mosi_nxt;
      rd_valid <= rd_done;
      if (rd_done) begin
        rd_data <= {rx_q[RD_BITS-2:0], MISO};
      end
    end
  end

  // Next state plus next values of the registered outputs. The line values
  // computed here appear on SS_n/MOSI during the following cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    is_rd_nxt = is_rd;
    ss_n_nxt  = 1'b1;
    mosi_nxt  = 1'b0;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    rx_shift  = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          tx_load   = 1'b1;
          is_rd_nxt = (cmd_data[9:8] == CMD_RD_DATA);
          if (!reject) begin
            state_nxt = SEL;
            ss_n_nxt  = 1'b0;
          end
        end
      end
      SEL: begin
        // Type bit is the MSB of the freshly loaded command
        state_nxt = CMD;
        ss_n_nxt  = 1'b0;
        mosi_nxt  = tx_q[PAYLOAD_BITS-1];
      end
      CMD: begin
        state_nxt = SHIFT;
        cnt_nxt   = '0;
        ss_n_nxt  = 1'b0;
        mosi_nxt  = tx_q[PAYLOAD_BITS-1];
        tx_shift  = 1'b1;
      end
      SHIFT: begin
        if (cnt == CNT_W'(PAYLOAD_BITS - 1)) begin
          cnt_nxt = '0;
          if (is_rd) begin
            state_nxt = (RD_GAP == 0) ? RECV : GAP;
            ss_n_nxt  = 1'b0;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          cnt_nxt  = cnt + CNT_W'(1);
          ss_n_nxt = 1'b0;
          mosi_nxt = tx_q[PAYLOAD_BITS-1];
          tx_shift = 1'b1;
        end
      end
      GAP: begin
        ss_n_nxt = 1'b0;
        if (cnt == CNT_W'(RD_GAP - 1)) begin
          state_nxt = RECV;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RECV: begin
        rx_shift = 1'b1;
        if (cnt == CNT_W'(RD_BITS - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          rd_done   = 1'b1;
        end else begin
          cnt_nxt  = cnt + CNT_W'(1);
          ss_n_nxt = 1'b0;
        end
      end
      DONE: begin
        if (cnt >= CNT_W'(MIN_IDLE - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
//============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master. A reference model turns
//               each accepted command into the expected per-cycle SS_n/MOSI
//               frame, reply byte and handshake values; a slave model drives
//               MISO from the same frame description.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_master;

  localparam int RD_GAP   = 2;
  localparam int MIN_IDLE = 1;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_data  = '0;
  logic       MISO      = 1'b0;
  logic       cmd_ready, rd_valid, err, SS_n, MOSI;
  logic [7:0] rd_data;

  spi_master #(.RD_GAP(RD_GAP), .MIN_IDLE(MIN_IDLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .err       (err),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  // Expected line/handshake values for one clock cycle
  typedef struct {
    bit       ss_n;
    bit       mosi;
    bit       ready;
    bit       rv;
    bit [7:0] rbyte;
    bit       err;
    bit       miso_en;
    bit       miso;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp   = 0;
  int         n_bad   = 0;
  int         acc_cnt = 0;
  logic [7:0] slave_byte = '0;
  logic [7:0] exp_rd     = '0;
  bit         model_flag = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void push_e(bit ss, bit mo, bit ready, bit rv, bit [7:0] b,
                                 bit er, bit men, bit mb);
    exp_t e;
    e.ss_n = ss; e.mosi = mo; e.ready = ready; e.rv = rv; e.rbyte = b;
    e.err = er; e.miso_en = men; e.miso = mb;
    exp_q.push_back(e);
  endfunction

  // Expand an accepted command into the cycles that follow its accept edge
  function automatic void model_accept(input logic [9:0] d, input logic [7:0] sb);
    bit rdd;
    bit rej;
    rdd = (d[9:8] == 2'b11);
    rej = 1'b0;
`ifdef SPI_MASTER_RD_ORDER_CHECK_EN
    if (rdd && !model_flag) rej = 1'b1;
    if (d[9:8] == 2'b10) model_flag = 1'b1;
    if (rdd) model_flag = 1'b0;
`endif
    if (rej) begin
      push_e(1, 0, 1, 0, 8'h00, 1, 0, 0);
    end else begin
      push_e(0, 0, 0, 0, 8'h00, 0, 0, 0);
      push_e(0, d[9], 0, 0, 8'h00, 0, 0, 0);
      for (int i = 9; i >= 0; i--) push_e(0, d[i], 0, 0, 8'h00, 0, 0, 0);
      if (rdd) begin
        for (int i = 0; i < RD_GAP; i++) push_e(0, 0, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 7; i >= 0; i--) push_e(0, 0, 0, 0, 8'h00, 0, 1, sb[i]);
      end
      for (int k = 0; k < MIN_IDLE; k++) push_e(1, 0, 0, rdd && (k == 0), sb, 0, 0, 0);
    end
  endfunction

  // Per-cycle comparison, MISO drive and accept prediction at each falling edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_rd     = '0;
        model_flag = 1'b0;
        check_eq("rst_ss_n", SS_n, 1);
        check_eq("rst_mosi", MOSI, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_rd_data", rd_data, 0);
        MISO = 1'($urandom);
      end else begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
        end else begin
          e.ss_n = 1; e.mosi = 0; e.ready = 1; e.rv = 0; e.rbyte = 0;
          e.err = 0; e.miso_en = 0; e.miso = 0;
        end
        if (e.rv) exp_rd = e.rbyte;
        check_eq("ss_n", SS_n, e.ss_n);
        check_eq("mosi", MOSI, e.mosi);
        check_eq("cmd_ready", cmd_ready, e.ready);
        check_eq("rd_valid", rd_valid, e.rv);
        check_eq("err", err, e.err);
        check_eq("rd_data", rd_data, exp_rd);
        MISO = e.miso_en ? e.miso : 1'($urandom);
        if (e.ready && cmd_valid) begin
          model_accept(cmd_data, slave_byte);
          acc_cnt++;
        end
      end
    end
  end

  // Offer one command and wait (bounded) until the model predicts acceptance
  task automatic send(input logic [9:0] d, input logic [7:0] sb, input bit keep);
    int start;
    bit got;
    cmd_data   = d;
    slave_byte = sb;
    cmd_valid  = 1'b1;
    start      = acc_cnt;
    got        = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != start) got = 1'b1;
    end
    check_eq("accepted", got, 1);
    if (!keep) begin
      cmd_valid = 1'b0;
      cmd_data  = 10'($urandom);
    end
  endtask

  // Assert reset a given number of cycles into the frame just accepted
  task automatic reset_mid(input int cyc);
    repeat (cyc) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_ss_n", SS_n, 1);
    check_eq("async_mosi", MOSI, 0);
    check_eq("async_rd_valid", rd_valid, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stimulus
    int gap;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_cycles(3);

    // Plain write frame
    send(10'b00_1010_0101, 8'h00, 0);
    idle_cycles(20);

    // Address then read-data with a known slave reply
    send(10'h233, 8'h00, 0);
    idle_cycles(2);
    send(10'h300, 8'hC5, 0);
    idle_cycles(30);

    // Three writes with valid held continuously
    send(10'h0A5, 8'h00, 1);
    send(10'h15A, 8'h00, 1);
    send(10'h0FF, 8'h00, 0);
    idle_cycles(20);

    // Reset during payload bit 5 of a read-data frame, then in its receive phase
    send(10'h3FF, 8'hA7, 0);
    reset_mid(7);
    idle_cycles(2);
    send(10'h300, 8'h3C, 0);
    reset_mid(18);
    idle_cycles(2);

    // Read-data straight after reset with no address sent
    send(10'h312, 8'h96, 0);
    idle_cycles(30);

    // Randomized command mix, gaps and back-to-back runs
    for (int n = 0; n < 60; n++) begin
      send(10'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0));
      gap = $urandom_range(0, 3);
      if (!cmd_valid) idle_cycles(gap);
    end
    cmd_valid = 1'b0;
    idle_cycles(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
